pll_reset_seq: RTL and testbench
================================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter N_CLK, default 5, SHALL set the number of clock domains sequenced (range 1..18).
REQ-002 Parameter PLL_RST_CYCLES, default 16, SHALL set the pll_rst_o pulse length in cycles (range >=1).
REQ-003 Parameter LOCK_STABLE, default 1024, SHALL set the consecutive synchronised-lock cycles required before release (range >=1).
REQ-004 Parameter STAGGER, default 8, SHALL set the cycles between successive domain reset releases (range >=1).
REQ-005 Parameter LOCK_TIMEOUT, default 65536, SHALL set the wait-for-lock limit in cycles, used only with LOCK_TIMEOUT_EN.
REQ-006 Port refclk, input, 1, SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1, SHALL be the reset: synchronous and active-high.
REQ-008 Port locked_i, input, 1, SHALL carry the PLL lock indication; it is asynchronous to refclk.
REQ-009 Port pll_rst_o, output, 1, SHALL drive the PLL reset.
REQ-010 Port dom_rst_o, output, N_CLK, SHALL drive active-high per-domain resets; bit k belongs to PLL output k.
REQ-011 Port ready_o, output, 1, SHALL indicate that all domains are released.
REQ-012 Port relock_cnt_o, output, 8, SHALL count lock losses after release, saturating at 255.

Function
REQ-013 locked_i SHALL pass through a 2-flop synchroniser; "lock" below means the synchronised value, which lags locked_i by 2 cycles.
REQ-014 The FSM SHALL have exactly these states: S_PLLRST, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN.
REQ-015 S_PLLRST SHALL drive pll_rst_o=1, dom_rst_o all ones and ready_o=0.
REQ-016 S_PLLRST SHALL last exactly PLL_RST_CYCLES cycles, then go to S_WAIT_LOCK.
REQ-017 S_WAIT_LOCK SHALL drive pll_rst_o=0 and SHALL go to S_STABLE on the first cycle with lock=1.
REQ-018 S_STABLE SHALL count consecutive lock=1 cycles.
REQ-019 In S_STABLE, lock=0 SHALL return the FSM to S_WAIT_LOCK and clear the stability counter.
REQ-020 S_STABLE SHALL go to S_RELEASE once the count reaches LOCK_STABLE.
REQ-021 In S_RELEASE, dom_rst_o[k] SHALL deassert exactly k*STAGGER cycles after S_RELEASE entry, bit 0 on the entry cycle.
REQ-022 Released bits SHALL stay low while in S_RELEASE and S_RUN.
REQ-023 One cycle after dom_rst_o[N_CLK-1] deasserts, the FSM SHALL enter S_RUN with ready_o=1.
REQ-024 lock=0 in S_RELEASE or S_RUN SHALL, on the next edge, set dom_rst_o all ones and ready_o=0.
REQ-025 On that same lock-loss edge, relock_cnt_o SHALL increment (saturating at 255) and the FSM SHALL enter S_PLLRST.
REQ-026 When N_CLK=1, S_RELEASE SHALL last 1 cycle.
REQ-027 Lock loss on the same cycle as a scheduled release SHALL take priority: no further bit releases.

Reset
REQ-028 While rst=1, the FSM SHALL be in S_PLLRST with pll_rst_o=1, dom_rst_o all ones, ready_o=0, relock_cnt_o=0, all counters and synchroniser flops 0.
REQ-029 Deasserting rst SHALL restart the full PLL_RST_CYCLES pulse.
REQ-030 rst asserted in any state SHALL abort the sequence on the next edge.

Configuration
REQ-031 With LOCK_TIMEOUT_EN defined, a counter SHALL run across S_WAIT_LOCK and S_STABLE (cleared on S_WAIT_LOCK entry from S_PLLRST).
REQ-032 With LOCK_TIMEOUT_EN defined, the FSM SHALL re-enter S_PLLRST when that counter reaches LOCK_TIMEOUT, without incrementing relock_cnt_o.
REQ-033 Without LOCK_TIMEOUT_EN, the timeout counter SHALL NOT exist and S_WAIT_LOCK SHALL wait indefinitely.

Structure
REQ-034 Package pll_reset_seq_pkg SHALL hold the state enum, the relock counter width constant (8) and a clog2-based counter-width function.
REQ-035 Sub-module sync2 (a 2-flop bit synchroniser) SHALL implement REQ-013.

Verification (N_CLK=3, PLL_RST_CYCLES=4, LOCK_STABLE=8, STAGGER=2, LOCK_TIMEOUT=32)
REQ-036 rst released, locked_i held 1 -> pll_rst_o high 4 cycles; dom_rst_o 111->110->100->000 at 2-cycle spacing; ready_o=1; relock_cnt_o=0.
REQ-037 locked_i glitches low for 1 cycle after 5 stable cycles -> S_WAIT_LOCK; release occurs only after 8 fresh stable cycles.
REQ-038 locked_i drops in S_RUN -> next edge dom_rst_o=111, ready_o=0, relock_cnt_o=1, pll_rst_o=1 for 4 cycles.
REQ-039 256 lock losses after release -> relock_cnt_o saturates at 255.
REQ-040 LOCK_TIMEOUT_EN defined, locked_i held 0 -> pll_rst_o re-pulses every 4+32 cycles, relock_cnt_o stays 0; without the macro, pll_rst_o stays 0.
REQ-041 rst asserted mid-S_RELEASE with dom_rst_o=110 -> next edge dom_rst_o=111, pll_rst_o=1, relock_cnt_o=0.

Source files
------------

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam int RELOCK_W = 8;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Two-flop synchroniser bringing a single asynchronous bit into the local clock.
module sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter chain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for stable lock, then releases domain resets staggered.
// Optional lock-wait timeout enabled by defining LOCK_TIMEOUT_EN.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int N_CLK          = 5,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_STABLE    = 1024,
    parameter int STAGGER        = 8,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked_i,
    output logic                pll_rst_o,
    output logic [N_CLK-1:0]    dom_rst_o,
    output logic                ready_o,
    output logic [RELOCK_W-1:0] relock_cnt_o
);

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
    localparam int MAX_B = (MAX_A > STAGGER) ? MAX_A : STAGGER;
    localparam int CNT_W = cnt_width(MAX_B - 1);

    localparam logic [CNT_W-1:0]    PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]    STAG_LAST   = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);
    localparam logic [N_CLK-1:0]    DOM_ONES    = {N_CLK{1'b1}};
    localparam logic [N_CLK-1:0]    DOM_ZERO    = {N_CLK{1'b0}};
    localparam logic [RELOCK_W-1:0] RELOCK_MAX  = {RELOCK_W{1'b1}};
    localparam logic [RELOCK_W-1:0] RELOCK_ZERO = {RELOCK_W{1'b0}};
    localparam logic [RELOCK_W-1:0] RELOCK_ONE  = RELOCK_W'(1);

    state_t                r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic                  r_pll, w_pll;
    logic [N_CLK-1:0]      r_dom, w_dom;
    logic                  r_ready, w_ready;
    logic [RELOCK_W-1:0]   r_relock, w_relock;
    logic                  w_lock;
    logic                  w_lose;

`ifdef LOCK_TIMEOUT_EN
    localparam int               TMO_W    = cnt_width(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    logic [TMO_W-1:0]            r_tmo, w_tmo;
`endif

    sync2 u_sync (
        .i_clk (refclk),
        .i_rst (rst),
        .i_d   (locked_i),
        .o_q   (w_lock)
    );

    assign w_lose = !w_lock && ((r_state == S_RELEASE) || (r_state == S_RUN));

    // Next-state and next-output decode; lock loss and timeout override the per-state result.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_pll    = r_pll;
        w_dom    = r_dom;
        w_ready  = r_ready;
        w_relock = r_relock;
        case (r_state)
            S_PLLRST: begin
                if (r_cnt == PLL_LAST) begin
                    w_state = S_WAIT_LOCK;
                    w_cnt   = CNT_ZERO;
                    w_pll   = 1'b0;
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                w_cnt = CNT_ZERO;
                if (w_lock) begin
                    w_state = S_STABLE;
                end else begin
                    w_state = S_WAIT_LOCK;
                end
            end
            S_STABLE: begin
                if (!w_lock) begin
                    w_state = S_WAIT_LOCK;
                    w_cnt   = CNT_ZERO;
                end else if (r_cnt == STABLE_LAST) begin
                    // Domain 0 is released on the very first RELEASE cycle.
                    w_state = S_RELEASE;
                    w_cnt   = CNT_ZERO;
                    w_dom   = DOM_ONES << 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (r_dom == DOM_ZERO) begin
                    w_state = S_RUN;
                    w_ready = 1'b1;
                end else if (r_cnt == STAG_LAST) begin
                    w_dom = r_dom << 1'b1;
                    w_cnt = CNT_ZERO;
                end else begin
                    w_cnt = r_cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                w_state = S_RUN;
            end
            default: begin
                w_state = S_PLLRST;
                w_cnt   = CNT_ZERO;
                w_pll   = 1'b1;
                w_dom   = DOM_ONES;
                w_ready = 1'b0;
            end
        endcase

        if (w_lose) begin
            w_state  = S_PLLRST;
            w_cnt    = CNT_ZERO;
            w_pll    = 1'b1;
            w_dom    = DOM_ONES;
            w_ready  = 1'b0;
            w_relock = (r_relock == RELOCK_MAX) ? r_relock : r_relock + RELOCK_ONE;
        end else begin
            w_relock = r_relock;
        end

`ifdef LOCK_TIMEOUT_EN
        // Timeout spans WAIT_LOCK and STABLE together; a fresh PLL pulse is not a lock loss.
        if ((r_state == S_WAIT_LOCK) || (r_state == S_STABLE)) begin
            if (r_tmo == TMO_LAST) begin
                w_tmo   = TMO_ZERO;
                w_state = S_PLLRST;
                w_cnt   = CNT_ZERO;
                w_pll   = 1'b1;
                w_dom   = DOM_ONES;
                w_ready = 1'b0;
            end else begin
                w_tmo = r_tmo + TMO_ONE;
            end
        end else begin
            w_tmo = TMO_ZERO;
        end
`endif
    end

    // State and registered-output update.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state  <= S_PLLRST;
            r_cnt    <= CNT_ZERO;
            r_pll    <= 1'b1;
            r_dom    <= DOM_ONES;
            r_ready  <= 1'b0;
            r_relock <= RELOCK_ZERO;
`ifdef LOCK_TIMEOUT_EN
            r_tmo    <= TMO_ZERO;
`endif
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_pll    <= w_pll;
            r_dom    <= w_dom;
            r_ready  <= w_ready;
            r_relock <= w_relock;
`ifdef LOCK_TIMEOUT_EN
            r_tmo    <= w_tmo;
`endif
        end
    end

    assign pll_rst_o    = r_pll;
    assign dom_rst_o    = r_dom;
    assign ready_o      = r_ready;
    assign relock_cnt_o = r_relock;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq against a timeline-based reference model.
module tb_pll_reset_seq;

    localparam int N  = 3;
    localparam int PR = 4;
    localparam int LS = 8;
    localparam int ST = 2;
    localparam int TO = 32;
`ifdef LOCK_TIMEOUT_EN
    localparam int TMO_HI = 12;
`else
    localparam int TMO_HI = 4;
`endif

    logic         refclk = 1'b0;
    logic         rst = 1'b1;
    logic         locked_i = 1'b0;
    logic         pll_rst_o;
    logic [N-1:0] dom_rst_o;
    logic         ready_o;
    logic [7:0]   relock_cnt_o;

    int total = 0;
    int bad = 0;

    // Model: remaining PLL-reset cycles, consecutive lock run, cycles since release start (-1 = none).
    int   m_pr = PR, m_run = 0, m_rel = -1, m_tmo = 0, m_relock = 0;
    logic m_h1 = 1'b0, m_h2 = 1'b0;
    logic         e_pll;
    logic [N-1:0] e_dom;
    logic         e_ready;
    logic [7:0]   e_relock;

    always #5 refclk = ~refclk;

    pll_reset_seq #(
        .N_CLK(N), .PLL_RST_CYCLES(PR), .LOCK_STABLE(LS), .STAGGER(ST), .LOCK_TIMEOUT(TO)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked_i     (locked_i),
        .pll_rst_o    (pll_rst_o),
        .dom_rst_o    (dom_rst_o),
        .ready_o      (ready_o),
        .relock_cnt_o (relock_cnt_o)
    );

    task automatic model_edge(input logic r, input logic l);
        logic lk;
        lk = m_h2;
        if (r) begin
            m_pr = PR; m_run = 0; m_rel = -1; m_relock = 0; m_h1 = 1'b0; m_h2 = 1'b0; m_tmo = 0;
        end else begin
            m_h2 = m_h1;
            m_h1 = l;
            if (m_pr > 0) begin
                m_pr = m_pr - 1;
                if (m_pr == 0) begin m_run = 0; m_tmo = 0; end
            end else if (m_rel < 0) begin
                m_tmo = m_tmo + 1;
`ifdef LOCK_TIMEOUT_EN
                if (m_tmo == TO) begin m_pr = PR; m_run = 0; end else
`endif
                if (lk) begin
                    m_run = m_run + 1;
                    if (m_run == LS + 1) begin m_rel = 0; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end else if (!lk) begin
                m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                m_pr = PR; m_rel = -1; m_run = 0;
            end else if (m_rel < (N - 1) * ST + 1) begin
                m_rel = m_rel + 1;
            end
        end
        e_pll = (m_pr > 0);
        for (int k = 0; k < N; k++) e_dom[k] = !(m_rel >= k * ST);
        e_ready  = (m_rel >= (N - 1) * ST + 1);
        e_relock = m_relock[7:0];
    endtask

    task automatic step(input logic r, input logic l);
        rst = r;
        locked_i = l;
        @(posedge refclk);
        model_edge(r, l);
        @(negedge refclk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b1, 1'b1);
        total++;
        if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset: got %h want %h", {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o},
                     {1'b1, 3'b111, 1'b0, 8'd0});
        end
    endtask

    task automatic test_nominal();
        int hi = 0, rdy_at = -1;
        int chg[$];
        logic [N-1:0] vals[$];
        logic [N-1:0] prev;
        do_reset();
        prev = dom_rst_o;
        for (int i = 0; i < 40; i++) begin
            total++;
            if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {e_pll, e_dom, e_ready, e_relock}) begin
                bad++;
                $display("FAIL nominal cyc %0d: got %h want %h", i,
                         {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o}, {e_pll, e_dom, e_ready, e_relock});
            end
            if (pll_rst_o) hi++;
            if (dom_rst_o != prev) begin chg.push_back(i); vals.push_back(dom_rst_o); end
            if (ready_o && rdy_at < 0) rdy_at = i;
            prev = dom_rst_o;
            step(1'b0, 1'b1);
        end
        total++;
        if (hi != PR) begin bad++; $display("FAIL nominal_pll_len: got %0d want %0d", hi, PR); end
        // 4 reset + 1 wait + 8 stable cycles, then releases every 2 cycles.
        total++;
        if (chg.size() != 3 || chg[0] != 13 || chg[1] != 15 || chg[2] != 17) begin
            bad++;
            $display("FAIL nominal_stagger: got %0d changes first=%0d want 3 at 13/15/17", chg.size(),
                     (chg.size() > 0) ? chg[0] : -1);
        end
        total++;
        if (vals.size() != 3 || vals[0] != 3'b110 || vals[1] != 3'b100 || vals[2] != 3'b000) begin
            bad++;
            $display("FAIL nominal_pattern: got %0d values want 110,100,000", vals.size());
        end
        total++;
        if (rdy_at != 18 || relock_cnt_o !== 8'd0) begin
            bad++;
            $display("FAIL nominal_ready: got ready at %0d cnt %0d want 18 and 0", rdy_at, relock_cnt_o);
        end
    endtask

    task automatic test_glitch();
        int first = -1;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            total++;
            if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {e_pll, e_dom, e_ready, e_relock}) begin
                bad++;
                $display("FAIL glitch cyc %0d: got %h want %h", i,
                         {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o}, {e_pll, e_dom, e_ready, e_relock});
            end
            if (first < 0 && dom_rst_o != 3'b111) first = i;
            step(1'b0, (i == 9) ? 1'b0 : 1'b1);
        end
        // Glitch seen on cycle 11 -> wait at 12, stable 13..20, release at 21.
        total++;
        if (first != 21) begin bad++; $display("FAIL glitch_release: got %0d want 21", first); end
    endtask

    task automatic test_relock();
        int hi = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            total++;
            if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {e_pll, e_dom, e_ready, e_relock}) begin
                bad++;
                $display("FAIL relock cyc %0d: got %h want %h", i,
                         {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o}, {e_pll, e_dom, e_ready, e_relock});
            end
            if (i == 28) begin
                total++;
                if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {1'b1, 3'b111, 1'b0, 8'd1}) begin
                    bad++;
                    $display("FAIL relock_edge: got %h want %h", {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o},
                             {1'b1, 3'b111, 1'b0, 8'd1});
                end
            end
            if (i >= 26 && pll_rst_o) hi++;
            step(1'b0, (i == 25) ? 1'b0 : 1'b1);
        end
        total++;
        if (hi != PR) begin bad++; $display("FAIL relock_pll_len: got %0d want %0d", hi, PR); end
    endtask

    task automatic test_rst_mid_release();
        int n = 0;
        while (dom_rst_o != 3'b110 && n < 40) begin
            total++;
            if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {e_pll, e_dom, e_ready, e_relock}) begin
                bad++;
                $display("FAIL midrel cyc %0d: got %h want %h", n,
                         {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o}, {e_pll, e_dom, e_ready, e_relock});
            end
            step(1'b0, 1'b1);
            n++;
        end
        total++;
        if (n >= 40 || relock_cnt_o !== 8'd1) begin
            bad++;
            $display("FAIL midrel_reach: got dom %b cnt %0d want 110 and 1", dom_rst_o, relock_cnt_o);
        end
        step(1'b1, 1'b1);
        total++;
        if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {1'b1, 3'b111, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL midrel_abort: got %h want %h", {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o},
                     {1'b1, 3'b111, 1'b0, 8'd0});
        end
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        for (int loss = 0; loss < 256; loss++) begin
            n = 0;
            while (!ready_o && n < 100) begin
                total++;
                if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {e_pll, e_dom, e_ready, e_relock}) begin
                    bad++;
                    $display("FAIL saturate loss %0d: got %h want %h", loss,
                             {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o}, {e_pll, e_dom, e_ready, e_relock});
                end
                step(1'b0, 1'b1);
                n++;
            end
            if (n >= 100) begin
                total++; bad++;
                $display("FAIL saturate_timeout: got no ready want ready within 100 at loss %0d", loss);
                break;
            end
            step(1'b0, 1'b0);
            for (int j = 0; j < 3; j++) step(1'b0, 1'b1);
        end
        total++;
        if (relock_cnt_o !== 8'd255 || relock_cnt_o !== e_relock) begin
            bad++;
            $display("FAIL saturate_value: got %0d want 255", relock_cnt_o);
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            total++;
            if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {e_pll, e_dom, e_ready, e_relock}) begin
                bad++;
                $display("FAIL timeout cyc %0d: got %h want %h", i,
                         {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o}, {e_pll, e_dom, e_ready, e_relock});
            end
            if (pll_rst_o) hi++;
            step(1'b0, 1'b0);
        end
        total++;
        if (hi != TMO_HI || relock_cnt_o !== 8'd0) begin
            bad++;
            $display("FAIL timeout_pulses: got %0d high cnt %0d want %0d and 0", hi, relock_cnt_o, TMO_HI);
        end
    endtask

    task automatic test_random();
        logic r, l;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            total++;
            if ({pll_rst_o, dom_rst_o, ready_o, relock_cnt_o} !== {e_pll, e_dom, e_ready, e_relock}) begin
                bad++;
                $display("FAIL random cyc %0d: got %h want %h", i,
                         {pll_rst_o, dom_rst_o, ready_o, relock_cnt_o}, {e_pll, e_dom, e_ready, e_relock});
            end
            r = ($urandom_range(0, 499) == 0);
            l = ($urandom_range(0, 99) >= 4);
            step(r, l);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_relock();
        test_rst_mid_release();
        test_saturate();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
